// File: rtl/wired_inst_buffer.sv
// wired_inst_buffer: decoupling FIFO between decode and rename.
// Accepts up to two masked packets per cycle, compacts them in order into a
// circular buffer, and presents the two oldest entries to the backend.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush_i           drop all buffered and incoming packets this cycle
//   in_valid_i/in_ready_o/in_mask_i/in_data_i     decode-side pair
//   out_valid_o/out_ready_i/out_mask_o/out_data_o backend-side pair
//   count_o           current occupancy
module wired_inst_buffer #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [1:0]              in_mask_i,
  input  logic [2*DATA_WIDTH-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [1:0]              out_mask_o,
  output logic [2*DATA_WIDTH-1:0] out_data_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rptr;
  logic [AW-1:0]         wptr;
  logic [CW-1:0]         cnt;

  logic                  push;
  logic                  pop;
  logic [1:0]            push_n;
  logic [1:0]            pop_n;
  logic [AW-1:0]         wptr_p1;
  logic [AW-1:0]         rptr_p1;
  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic [DATA_WIDTH-1:0] first_wdata;
  logic                  first_we;
  logic                  second_we;

  assign slot0 = in_data_i[DATA_WIDTH-1:0];
  assign slot1 = in_data_i[2*DATA_WIDTH-1:DATA_WIDTH];

  // Handshake flags: both sides are forced closed during a flush.
  assign in_ready_o  = (cnt <= CW'(DEPTH - 2)) && !flush_i;
  assign out_valid_o = (cnt != '0) && !flush_i;
  assign out_mask_o  = (cnt >= CW'(2)) ? 2'b11 : 2'b01;
  assign count_o     = cnt;

  assign push   = in_valid_i && in_ready_o;
  assign pop    = out_valid_o && out_ready_i;
  assign push_n = push ? (2'({1'b0, in_mask_i[0]}) + 2'({1'b0, in_mask_i[1]})) : 2'd0;
  assign pop_n  = pop ? (out_mask_o[1] ? 2'd2 : 2'd1) : 2'd0;

  assign wptr_p1 = wptr + AW'(1);
  assign rptr_p1 = rptr + AW'(1);

  // Compaction: the oldest valid slot always lands at wptr.
  assign first_we    = push && (in_mask_i != 2'b00);
  assign second_we   = push && (in_mask_i == 2'b11);
  assign first_wdata = in_mask_i[0] ? slot0 : slot1;

  // Storage has no reset; validity is tracked solely by cnt.
  always_ff @(posedge clk) begin
    if (first_we) begin
      mem[wptr] <= first_wdata;
    end
    if (second_we) begin
      mem[wptr_p1] <= slot1;
    end
  end

  // Pointer and occupancy update; flush returns to the empty origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      rptr <= rptr + AW'(pop_n);
      wptr <= wptr + AW'(push_n);
      cnt  <= cnt + CW'(push_n) - CW'(pop_n);
    end
  end

  // No same-cycle bypass: reads see only previously written entries.
  assign out_data_o = {mem[rptr_p1], mem[rptr]};

  a_cnt_bound : assert property (@(posedge clk) disable iff (rst) cnt <= CW'(DEPTH));
  a_mask_legal : assert property (@(posedge clk) disable iff (rst) out_mask_o[0]);

endmodule

// File: doc/wired_inst_buffer.md
Name: wired_inst_buffer

Overview:
- Decoupling FIFO between the decode stage and the backend rename stage.
- Accepts up to two decoded instruction packets per cycle, each with a per-slot mask, and compacts them in order into a circular buffer.
- Presents up to two oldest packets to the backend as a valid/ready/mask bundle.
- Discards all contents on a pipeline flush (branch redirect or exception).

Parameters:
- DATA_WIDTH, 128: width of one instruction packet (the packed decode control pack); treated as opaque.
- DEPTH, 8: number of entries. Must be a power of two and at least 4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all buffered and incoming packets this cycle
- in_valid_i  in  1  decode offers a packet pair
- in_ready_o  out  1  buffer can accept the offered pair
- in_mask_i  in  2  per-slot valid; any of 00/01/10/11 is legal
- in_data_i  in  2*DATA_WIDTH  slot 0 is the older packet
- out_valid_o  out  1  at least one packet available
- out_ready_i  in  1  backend accepts the whole masked pair
- out_mask_o  out  2  01 or 11 only
- out_data_o  out  2*DATA_WIDTH  slot 0 is the oldest entry
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State:
  - mem[DEPTH] of DATA_WIDTH, with no reset.
  - rptr and wptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - cnt, $clog2(DEPTH)+1 bits.
- Reset, asynchronous on rst high: rptr=0, wptr=0, cnt=0.
  - Outputs after reset: out_valid_o=0, out_mask_o=01, count_o=0, in_ready_o=1.
  - out_data_o is don't-care after reset.
- in_ready_o = (cnt <= DEPTH-2) && !flush_i.
  - Computed from registered cnt only; a same-cycle pop does not raise it.
- Push condition: push = in_valid_i && in_ready_o. Push count = popcount(in_mask_i).
- Compaction on push:
  - Mask 11: slot0 is written to mem[wptr], slot1 to mem[wptr+1].
  - Mask 01: slot0 is written to mem[wptr].
  - Mask 10: slot1 is written to mem[wptr].
  - Mask 00: handshake completes and nothing is written.
  - wptr advances by the push count, with wrap.
- Output side:
  - out_valid_o = (cnt != 0) && !flush_i.
  - out_mask_o = (cnt >= 2) ? 11 : 01.
  - out_data_o slot0 = mem[rptr], slot1 = mem[rptr+1 mod DEPTH]. Slot1 is don't-care when the mask is 01.
  - pop = out_valid_o && out_ready_i. Pop count = popcount(out_mask_o). rptr advances by the pop count.
- Ordering: the backend consumes all masked slots or none; partial acceptance does not exist.
- Simultaneous push and pop are allowed: cnt_next = cnt + pushcnt - popcnt.
- Latency: a packet written in cycle N is visible on out_data_o in cycle N+1. There is no same-cycle bypass.
- Full/empty:
  - cnt==DEPTH-1 or cnt==DEPTH: in_ready_o=0.
  - cnt==0: out_valid_o=0 and out_ready_i is ignored.
- Wrap-around: a pair that straddles index DEPTH-1 to index 0 is written and read correctly.
- Flush:
  - When flush_i=1, the next state is rptr=wptr=0 and cnt=0.
  - Any push or pop in the same cycle is suppressed, because in_ready_o and out_valid_o are forced to 0.
  - The buffer is usable the following cycle.
- Reset mid-operation: the asynchronous clear takes effect immediately. Memory contents are not cleared, and stale data must never be marked valid.
- Assertions:
  - cnt <= DEPTH.
  - out_mask_o is never 00 or 10.
  - Pushing with in_ready_o=0 is not an error; it has no effect.

Test Plan:
- Reset, then push mask 11 with data A,B in cycle 0 -> cycle 1: out_valid_o=1, out_mask_o=11, out_data_o={B,A}, count_o=2.
- Push mask 10 with slot1=C into an empty buffer, out_ready_i=1 -> next cycle: out_mask_o=01, slot0=C; after the pop, count_o=0 and out_valid_o=0.
- Fill with DEPTH=8 using four 11 pushes while out_ready_i=0 -> in_ready_o drops to 0 once count_o=8.
  - One pop of 2 -> count_o=6 and in_ready_o=1 the following cycle.
- Wrap: with rptr=wptr=7 and cnt=0, push D,E -> D is stored at index 7 and E at index 0; the output shows {E,D} with mask 11, and after the pop rptr=1.
- Simultaneous: with cnt=3, pop 2 and push 11 in the same cycle -> count_o=3 next, and the order is preserved (old 3rd entry, then new slot0, then new slot1).
- Flush with cnt=5 while in_valid_i=1 and out_ready_i=1 -> that cycle out_valid_o=0 and in_ready_o=0; next cycle count_o=0.
  - Async rst pulse mid-stream -> count_o=0 immediately, without waiting for a clock edge.
